// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-side fields and controls in, EX-side registered fields
// and upstream write enables out. master = ID/controller side, slave = the pipe register.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [3:0]        id_ex;
  logic [2:0]        id_m;
  logic [1:0]        id_wb;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              ex_valid;
  logic [3:0]        ex_ex;
  logic [2:0]        ex_m;
  logic [1:0]        ex_wb;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic              load_use;
  logic              pc_write;
  logic              if_id_write;

  modport master (
    output stall, flush, id_valid, id_ex, id_m, id_wb,
           id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ex, ex_m, ex_wb, ex_pc4, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, load_use, pc_write, if_id_write
  );

  modport slave (
    input  stall, flush, id_valid, id_ex, id_m, id_wb,
           id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_ex, ex_m, ex_wb, ex_pc4, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, load_use, pc_write, if_id_write
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, hold and branch flush.
// Defining ID_EX_PERF_CNT_EN adds the bubble_cnt / flush_cnt performance counters.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic             clk,
  input logic             rst,
  id_ex_pipe_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
`endif
);
  logic              id_uses_rt_s;
  logic              rt_hit_s;
  logic              load_use_s;
  logic              upstream_we_s;
  logic              ctl_clear_s;
  logic              ex_valid_r;
  logic [3:0]        ex_ex_r;
  logic [2:0]        ex_m_r;
  logic [1:0]        ex_wb_r;
  logic [DATA_W-1:0] ex_pc4_r;
  logic [DATA_W-1:0] ex_rd1_r;
  logic [DATA_W-1:0] ex_rd2_r;
  logic [DATA_W-1:0] ex_imm_r;
  logic [REG_W-1:0]  ex_rs_r;
  logic [REG_W-1:0]  ex_rt_r;
  logic [REG_W-1:0]  ex_rd_r;

  // Load-use detection and upstream write enables; a load into $0 never stalls
  always_comb begin
    id_uses_rt_s = bus.id_ex[3] | bus.id_m[0] | bus.id_m[2];
    rt_hit_s     = (ex_rt_r == bus.id_rs) | (id_uses_rt_s & (ex_rt_r == bus.id_rt));
    load_use_s   = ex_valid_r & ex_m_r[1] & bus.id_valid
                   & (ex_rt_r != {REG_W{1'b0}}) & rt_hit_s;
    if (rst) begin
      upstream_we_s = 1'b1;
    end else begin
      upstream_we_s = ~(load_use_s | bus.stall);
    end
    ctl_clear_s = bus.flush | (~bus.stall & load_use_s);
  end

  // Control bundle: flush beats stall, stall beats the load-use bubble
  always_ff @(posedge clk) begin
    if (rst || ctl_clear_s) begin
      ex_valid_r <= 1'b0;
      ex_ex_r    <= 4'b0000;
      ex_m_r     <= 3'b000;
      ex_wb_r    <= 2'b00;
    end else if (bus.stall) begin
      ex_valid_r <= ex_valid_r;
      ex_ex_r    <= ex_ex_r;
      ex_m_r     <= ex_m_r;
      ex_wb_r    <= ex_wb_r;
    end else begin
      ex_valid_r <= bus.id_valid;
      ex_ex_r    <= bus.id_valid ? bus.id_ex : 4'b0000;
      ex_m_r     <= bus.id_valid ? bus.id_m  : 3'b000;
      ex_wb_r    <= bus.id_valid ? bus.id_wb : 2'b00;
    end
  end

  // Data and specifier fields load on every non-held edge, bubbles included
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc4_r <= {DATA_W{1'b0}};
      ex_rd1_r <= {DATA_W{1'b0}};
      ex_rd2_r <= {DATA_W{1'b0}};
      ex_imm_r <= {DATA_W{1'b0}};
      ex_rs_r  <= {REG_W{1'b0}};
      ex_rt_r  <= {REG_W{1'b0}};
      ex_rd_r  <= {REG_W{1'b0}};
    end else if (bus.flush || !bus.stall) begin
      ex_pc4_r <= bus.id_pc4;
      ex_rd1_r <= bus.id_rd1;
      ex_rd2_r <= bus.id_rd2;
      ex_imm_r <= bus.id_imm;
      ex_rs_r  <= bus.id_rs;
      ex_rt_r  <= bus.id_rt;
      ex_rd_r  <= bus.id_rd;
    end else begin
      ex_pc4_r <= ex_pc4_r;
      ex_rd1_r <= ex_rd1_r;
      ex_rd2_r <= ex_rd2_r;
      ex_imm_r <= ex_imm_r;
      ex_rs_r  <= ex_rs_r;
      ex_rt_r  <= ex_rt_r;
      ex_rd_r  <= ex_rd_r;
    end
  end

  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_ex       = ex_ex_r;
  assign bus.ex_m        = ex_m_r;
  assign bus.ex_wb       = ex_wb_r;
  assign bus.ex_pc4      = ex_pc4_r;
  assign bus.ex_rd1      = ex_rd1_r;
  assign bus.ex_rd2      = ex_rd2_r;
  assign bus.ex_imm      = ex_imm_r;
  assign bus.ex_rs       = ex_rs_r;
  assign bus.ex_rt       = ex_rt_r;
  assign bus.ex_rd       = ex_rd_r;
  assign bus.load_use    = load_use_s;
  assign bus.pc_write    = upstream_we_s;
  assign bus.if_id_write = upstream_we_s;

`ifdef ID_EX_PERF_CNT_EN
  logic        bubble_taken_s;
  logic [31:0] bubble_cnt_r;
  logic [31:0] flush_cnt_r;

  assign bubble_taken_s = ~bus.flush & ~bus.stall & load_use_s;

  // Event counters; a held stall edge is neither a bubble nor a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= 32'd0;
      flush_cnt_r  <= 32'd0;
    end else begin
      bubble_cnt_r <= bubble_cnt_r + {31'd0, bubble_taken_s};
      flush_cnt_r  <= flush_cnt_r + {31'd0, bus.flush};
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`endif
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It latches the ID-stage control bundles (EX[3:0], M[2:0], WB[1:0]) and the operand and register fields, and presents them to the EX stage.
- It contains the load-use hazard detector. On a load-use hazard it inserts a bubble into EX and freezes the PC and IF/ID.
- It also handles external stall (hold) and branch flush.

Parameters:
- DATA_W, 32, width of the PC+4, register read data and sign-extended immediate.
- REG_W, 5, register specifier width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  downstream hold; freezes ID/EX contents
- flush  input  1  branch taken / squash; ID/EX becomes a bubble
- id_valid  input  1  ID stage holds a real instruction
- id_ex  input  4  {RegDst, ALUOp1, ALUSrc, ALUOp0}
- id_m  input  3  {Branch, MemRead, MemWrite}
- id_wb  input  2  {RegWrite, MemtoReg}
- id_pc4, id_rd1, id_rd2, id_imm  input  DATA_W each  PC+4, rs data, rt data, sign-extended immediate
- id_rs, id_rt, id_rd  input  REG_W each  register specifiers
- ex_valid  output  1  EX holds a real instruction
- ex_ex, ex_m, ex_wb  output  4/3/2  registered control bundles
- ex_pc4, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  output  REG_W  registered specifiers
- load_use  output  1  combinational hazard flag
- pc_write, if_id_write  output  1 each  upstream write enables

Behaviour:
- All outputs are registered except load_use, pc_write and if_id_write.
- Reset: every registered output clears to 0, including ex_valid and all control bits. The cleared state is a NOP bubble.
- Derived signal: id_uses_rt = id_ex[3] | id_m[0] | id_m[2]. This covers R-type, SW and BEQ.
- load_use = ex_valid & ex_m[1] & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- pc_write = if_id_write = ~(load_use | stall). Both are forced to 1 while rst is high.
- Per-edge update, in strict priority order:
  1. rst: clear everything.
  2. flush: clear ex_valid, ex_ex, ex_m and ex_wb; data and specifier fields load from ID (don't-care). Flush overrides stall and load_use in the same cycle.
  3. stall: hold all registers unchanged; load_use is still computed but no bubble is inserted.
  4. load_use: insert a bubble (ex_valid and all control cleared); data fields load from ID. The ID instruction is held upstream and re-presented next cycle.
  5. Otherwise: load all fields from ID; ex_valid <= id_valid. When id_valid = 0, control bits load as 0.
- Latency: 1 cycle from ID inputs to EX outputs.
- A load followed by a dependent instruction yields exactly one bubble. After that bubble, ex_m[1] = 0, so load_use deasserts.
- A register write to $0 (ex_rt == 0) never causes a stall.
- Asserting rst mid-stall or mid-hazard clears state on that edge; the next cycle behaves as if from reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two outputs:
  - bubble_cnt (32-bit): increments on each edge where a load-use bubble is inserted (priority 4 taken).
  - flush_cnt (32-bit): increments on each edge where flush is taken.
  - Both counters clear on rst, wrap modulo 2^32 and do not count while stall holds.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs → all ex_* = 0, ex_valid = 0, pc_write = 1, load_use = 0.
- Pass-through: present an R-type (id_ex = 1100, id_wb = 10, id_rs = 8, id_rt = 9, id_rd = 10, id_rd1 = 0x11) → one cycle later ex_ex = 1100, ex_wb = 10, ex_rd = 10, ex_rd1 = 0x11, ex_valid = 1.
- Load-use: LW in EX (ex_m = 010, ex_rt = 9), then R-type in ID with id_rs = 9 → load_use = 1 and pc_write = 0 for one cycle; next ex_* control = 0; the following cycle the R-type loads with ex_ex = 1100.
- No-hazard cases:
  - LW in EX with ex_rt = 0 → load_use = 0.
  - LW in EX with ex_rt = 9, and LW in ID with id_rt = 9, id_rs = 4 → load_use = 0 (id_uses_rt = 0).
- Priority: flush and stall asserted together with a valid ID instruction → EX control = 0 and ex_valid = 0 next cycle. Stall alone for 3 cycles → EX outputs unchanged for those 3 cycles.
- With ID_EX_PERF_CNT_EN: 3 load-use bubbles and 2 flushes → bubble_cnt = 3, flush_cnt = 2; rst → both 0.
